branch_control_unit: RTL and testbench
======================================

# branch_control_unit

Hardwired control sequencer that drives the datapath control inputs for instruction fetch and the control-transfer subset of the ISA: branch (brzr/brnz/brpl/brmi), jr, nop and halt. The testbench currently hand-sequences these control inputs; this block generates them from the IR opcode, the CON flip-flop result and a memory-ready handshake. It sits beside `datapath`, and its outputs connect one-to-one to the datapath control ports of the same names.

## Interface
- `RST_SETTLE`, default 1: number of cycles spent in `S_RST` (asserting `DP_clear`) after reset release; minimum 1.
- `Clock`, in, 1: system clock; all state changes happen on the rising edge.
- `Clear`, in, 1: asynchronous, active-low reset.
- `IR`, in, 32: instruction register contents.
  - `IR[31:27]`: opcode.
  - `IR[26:23]`: Ra.
  - `IR[20:19]`: C2, the branch condition.
- `CON_FF`, in, 1: branch-condition result from the datapath, valid from the cycle after `CON_enable`.
- `Mem_ready`, in, 1: RAM read data is valid this cycle.
- `Start`, in, 1: single-cycle pulse that resumes execution from `S_HALT`.
- `DP_clear`, out, 1: active-high clear to the datapath.
- `Run`, out, 1: processor is running.
- Datapath control outputs, each out, 1: `PCout`, `MAR_enable`, `IncPC`, `ZLowIn`, `ZHighIn`, `ZLowout`, `PC_enable`, `MDR_read`, `MDR_enable`, `MDRout`, `IR_enable`, `Gra`, `Grb`, `Grc`, `R_in`, `R_out`, `CON_enable`, `Y_enable`, `Cout`.

## Operation
- Moore FSM. Every output is decoded from the present state only, except:
  - `PC_enable` in `S_T6`, which is gated by `CON_FF`;
  - `PC_enable` in `S_T1`, which is gated by `Mem_ready`.
- States: `S_RST`, `S_T0` to `S_T6`, `S_HALT`.
- `S_RST`: assert `DP_clear`. Stay for `RST_SETTLE` cycles, then go to `S_T0`.
- Fetch:
  - `S_T0`: `PCout`, `MAR_enable`, `IncPC`, `ZLowIn`. The Z register captures PC+1.
  - `S_T1`: `MDR_read`, `MDR_enable`, `ZLowout`.
    - `PC_enable` is asserted only in the cycle where `Mem_ready`=1.
    - Stay in `S_T1` while `Mem_ready`=0. On `Mem_ready`=1 go to `S_T2`.
  - `S_T2`: `MDRout`, `IR_enable`. Go to `S_T3`.
- Decode happens in `S_T3`, on the `IR` value loaded by `S_T2`:
  - branch (`5'b10010`): `S_T3` asserts `Gra`, `R_out`, `CON_enable`. Then:
    - `S_T4`: `PCout`, `Y_enable`.
    - `S_T5`: `Cout`, `ZLowIn`, `ZHighIn`.
    - `S_T6`: `ZLowout`, plus `PC_enable` only if `CON_FF`=1. Then go to `S_T0`.
  - jr (`5'b10011`): `S_T3` asserts `Gra`, `R_out`, `PC_enable`. Then go to `S_T0`.
  - nop (`5'b11001`) and every opcode not listed: `S_T3` asserts nothing. Then go to `S_T0`.
  - halt (`5'b11010`): go to `S_HALT`.
- `S_HALT`:
  - `Run`=0 and all control outputs are 0.
  - Stay in `S_HALT` until `Start`=1, then go to `S_T0`. The PC is preserved.
- `Run`=1 in every state except `S_RST` and `S_HALT`.
- Condition evaluation (C2 against Ra) belongs to the datapath CON logic; this block only sequences it.

## Timing
- Reset (`Clear`=0), asynchronous:
  - state goes to `S_RST` immediately, including mid-instruction and during a memory wait;
  - `DP_clear`=1, `Run`=0, all other outputs 0.
- Instruction latency with `Mem_ready` high in `S_T1`:
  - branch: 7 cycles;
  - jr: 4 cycles;
  - nop or unsupported opcode: 4 cycles;
  - halt: 4 cycles to `S_HALT`.
- Each cycle of `Mem_ready`=0 in `S_T1` adds exactly 1 cycle. While waiting, `MDR_read`, `MDR_enable` and `ZLowout` stay asserted.
- `Mem_ready` is ignored outside `S_T1`.
- `Start` is ignored outside `S_HALT`. If `Start` is asserted on the same edge the FSM enters `S_HALT`, it is ignored.
- `CON_FF` is sampled only in `S_T6`.
- Each state's output set is valid for the whole cycle, and state changes occur only on the rising edge.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum, 4-bit encoding;
  - opcode constants (the full ISA list, including the ALU, load/store and I/O opcodes reserved for later);
  - the IR field bit positions.
- Sub-module `ctrl_decode`: combinational. Maps `IR[31:27]` to the one-hot class `{is_branch, is_jr, is_halt, is_other}`.
- The FSM and the output decode stay in `branch_control_unit`.

## Test plan
1. Reset and settle:
   - Hold `Clear`=0 for 3 cycles → `DP_clear`=1, all other outputs 0, `Run`=0.
   - Release `Clear` → one `S_RST` cycle, then `S_T0` with `PCout`=`MAR_enable`=`IncPC`=`ZLowIn`=1.
2. Taken branch:
   - `IR`=32'h91000023 (brzr r2,35), `CON_FF`=1, `Mem_ready`=1.
   - → `S_T3` asserts `Gra`+`R_out`+`CON_enable`; `S_T6` asserts `ZLowout`+`PC_enable`.
   - `S_T0` follows 7 cycles after the previous `S_T0`.
3. Not-taken branch:
   - `IR`=32'h91080023 (brnz r2,35), `CON_FF`=0.
   - → `PC_enable`=0 throughout `S_T6`; the other outputs match scenario 2.
4. Memory wait:
   - `Mem_ready`=0 for 3 cycles in `S_T1`.
   - → `S_T1` lasts 4 cycles; `PC_enable` pulses only in the 4th; the total branch takes 10 cycles.
5. jr, then halt:
   - `IR`=opcode 10011 → `S_T3` asserts `Gra`+`R_out`+`PC_enable`.
   - Next instruction, opcode 11010 → `Run`=0 and the FSM stays in `S_HALT` for 20 cycles.
   - `Start` pulse → `S_T0` on the next cycle.
6. Reset mid-branch:
   - Assert `Clear`=0 during `S_T5`.
   - → outputs clear asynchronously before the next edge; after release, the sequence restarts from `S_RST`.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types: FSM state encoding, ISA opcodes, IR field positions
// and the decoded instruction class.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  // Full ISA opcode map; only the control-transfer subset is sequenced today.
  localparam logic [4:0] OPC_LD     = 5'b00000;
  localparam logic [4:0] OPC_LDI    = 5'b00001;
  localparam logic [4:0] OPC_ST     = 5'b00010;
  localparam logic [4:0] OPC_ADD    = 5'b00011;
  localparam logic [4:0] OPC_SUB    = 5'b00100;
  localparam logic [4:0] OPC_AND    = 5'b00101;
  localparam logic [4:0] OPC_OR     = 5'b00110;
  localparam logic [4:0] OPC_ROR    = 5'b00111;
  localparam logic [4:0] OPC_ROL    = 5'b01000;
  localparam logic [4:0] OPC_SHR    = 5'b01001;
  localparam logic [4:0] OPC_SHRA   = 5'b01010;
  localparam logic [4:0] OPC_SHL    = 5'b01011;
  localparam logic [4:0] OPC_ADDI   = 5'b01100;
  localparam logic [4:0] OPC_ANDI   = 5'b01101;
  localparam logic [4:0] OPC_ORI    = 5'b01110;
  localparam logic [4:0] OPC_DIV    = 5'b01111;
  localparam logic [4:0] OPC_MUL    = 5'b10000;
  localparam logic [4:0] OPC_NEG    = 5'b10001;
  localparam logic [4:0] OPC_BRANCH = 5'b10010;
  localparam logic [4:0] OPC_JR     = 5'b10011;
  localparam logic [4:0] OPC_JAL    = 5'b10100;
  localparam logic [4:0] OPC_IN     = 5'b10101;
  localparam logic [4:0] OPC_OUT    = 5'b10110;
  localparam logic [4:0] OPC_MFHI   = 5'b10111;
  localparam logic [4:0] OPC_MFLO   = 5'b11000;
  localparam logic [4:0] OPC_NOP    = 5'b11001;
  localparam logic [4:0] OPC_HALT   = 5'b11010;
  localparam logic [4:0] OPC_NOT    = 5'b11011;

  localparam int IR_OPC_MSB = 31;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_C2_MSB  = 20;
  localparam int IR_C2_LSB  = 19;

  typedef struct packed {
    logic is_branch;
    logic is_jr;
    logic is_halt;
    logic is_other;
  } ctrl_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: one-hot {is_branch, is_jr, is_halt, is_other}.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]  opcode,
  output ctrl_class_t op_class
);

  // Opcode to instruction-class map; nop and all unsequenced opcodes are "other".
  always_comb begin
    op_class = '0;
    case (opcode)
      OPC_BRANCH: op_class.is_branch = 1'b1;
      OPC_JR:     op_class.is_jr     = 1'b1;
      OPC_HALT:   op_class.is_halt   = 1'b1;
      default:    op_class.is_other  = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_control_unit.sv
// Hardwired fetch / control-transfer sequencer driving the datapath control ports
// from the IR opcode, the CON flip-flop and the memory-ready handshake.
module branch_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int RST_SETTLE = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Mem_ready,
  input  logic        Start,
  output logic        DP_clear,
  output logic        Run,
  output logic        PCout,
  output logic        MAR_enable,
  output logic        IncPC,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic        PC_enable,
  output logic        MDR_read,
  output logic        MDR_enable,
  output logic        MDRout,
  output logic        IR_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        CON_enable,
  output logic        Y_enable,
  output logic        Cout
);

  localparam int CNT_W = (RST_SETTLE > 1) ? $clog2(RST_SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RST_SETTLE - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] settle_cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  ctrl_class_t      op_class_s;
  logic             ir_unused_s;

  // Ra and C2 are consumed by the datapath CON logic, not here.
  assign ir_unused_s = ^IR[IR_RA_MSB:0];

  ctrl_decode u_decode (
    .opcode   (IR[IR_OPC_MSB:IR_OPC_LSB]),
    .op_class (op_class_s)
  );

  // State and reset-settle counter registers.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_r      <= S_RST;
      settle_cnt_r <= '0;
    end else begin
      state_r      <= next_state_s;
      settle_cnt_r <= next_cnt_s;
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = '0;
    DP_clear     = 1'b0;
    Run          = 1'b1;
    PCout        = 1'b0;
    MAR_enable   = 1'b0;
    IncPC        = 1'b0;
    ZLowIn       = 1'b0;
    ZHighIn      = 1'b0;
    ZLowout      = 1'b0;
    PC_enable    = 1'b0;
    MDR_read     = 1'b0;
    MDR_enable   = 1'b0;
    MDRout       = 1'b0;
    IR_enable    = 1'b0;
    Gra          = 1'b0;
    Grb          = 1'b0;
    Grc          = 1'b0;
    R_in         = 1'b0;
    R_out        = 1'b0;
    CON_enable   = 1'b0;
    Y_enable     = 1'b0;
    Cout         = 1'b0;

    case (state_r)
      S_RST: begin
        DP_clear = 1'b1;
        Run      = 1'b0;
        if (settle_cnt_r == SETTLE_LAST) begin
          next_state_s = S_T0;
        end else begin
          next_cnt_s = settle_cnt_r + CNT_W'(1);
        end
      end
      S_T0: begin
        PCout        = 1'b1;
        MAR_enable   = 1'b1;
        IncPC        = 1'b1;
        ZLowIn       = 1'b1;
        next_state_s = S_T1;
      end
      S_T1: begin
        // Z already holds PC+1; it is written back only once the read completes.
        MDR_read   = 1'b1;
        MDR_enable = 1'b1;
        ZLowout    = 1'b1;
        PC_enable  = Mem_ready;
        if (Mem_ready) begin
          next_state_s = S_T2;
        end else begin
          next_state_s = S_T1;
        end
      end
      S_T2: begin
        MDRout       = 1'b1;
        IR_enable    = 1'b1;
        next_state_s = S_T3;
      end
      S_T3: begin
        if (op_class_s.is_branch) begin
          Gra          = 1'b1;
          R_out        = 1'b1;
          CON_enable   = 1'b1;
          next_state_s = S_T4;
        end else if (op_class_s.is_jr) begin
          Gra          = 1'b1;
          R_out        = 1'b1;
          PC_enable    = 1'b1;
          next_state_s = S_T0;
        end else if (op_class_s.is_halt) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_T0;
        end
      end
      S_T4: begin
        PCout        = 1'b1;
        Y_enable     = 1'b1;
        next_state_s = S_T5;
      end
      S_T5: begin
        Cout         = 1'b1;
        ZLowIn       = 1'b1;
        ZHighIn      = 1'b1;
        next_state_s = S_T6;
      end
      S_T6: begin
        ZLowout      = 1'b1;
        PC_enable    = CON_FF;
        next_state_s = S_T0;
      end
      S_HALT: begin
        Run = 1'b0;
        if (Start) begin
          next_state_s = S_T0;
        end else begin
          next_state_s = S_HALT;
        end
      end
      default: begin
        DP_clear     = 1'b1;
        Run          = 1'b0;
        next_state_s = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed self-checking bench for branch_control_unit: reset, branches, memory
// wait, nop/other, jr, halt/start and asynchronous reset mid-instruction.
module tb_branch_control_unit;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Mem_ready;
  logic        Start;
  logic DP_clear, Run, PCout, MAR_enable, IncPC, ZLowIn, ZHighIn, ZLowout;
  logic PC_enable, MDR_read, MDR_enable, MDRout, IR_enable, Gra, Grb, Grc;
  logic R_in, R_out, CON_enable, Y_enable, Cout;

  int checks = 0;
  int errors = 0;

  logic [20:0] obs;
  assign obs = {DP_clear, Run, PCout, MAR_enable, IncPC, ZLowIn, ZHighIn, ZLowout,
                PC_enable, MDR_read, MDR_enable, MDRout, IR_enable, Gra, Grb, Grc,
                R_in, R_out, CON_enable, Y_enable, Cout};

  localparam logic [20:0] B_DPC  = 21'h100000;
  localparam logic [20:0] B_RUN  = 21'h080000;
  localparam logic [20:0] B_PCO  = 21'h040000;
  localparam logic [20:0] B_MAR  = 21'h020000;
  localparam logic [20:0] B_INC  = 21'h010000;
  localparam logic [20:0] B_ZLI  = 21'h008000;
  localparam logic [20:0] B_ZHI  = 21'h004000;
  localparam logic [20:0] B_ZLO  = 21'h002000;
  localparam logic [20:0] B_PCE  = 21'h001000;
  localparam logic [20:0] B_MRD  = 21'h000800;
  localparam logic [20:0] B_MDE  = 21'h000400;
  localparam logic [20:0] B_MDO  = 21'h000200;
  localparam logic [20:0] B_IRE  = 21'h000100;
  localparam logic [20:0] B_GRA  = 21'h000080;
  localparam logic [20:0] B_ROUT = 21'h000008;
  localparam logic [20:0] B_CONE = 21'h000004;
  localparam logic [20:0] B_YE   = 21'h000002;
  localparam logic [20:0] B_COUT = 21'h000001;

  localparam logic [20:0] E_RST   = B_DPC;
  localparam logic [20:0] E_T0    = B_RUN | B_PCO | B_MAR | B_INC | B_ZLI;
  localparam logic [20:0] E_T1W   = B_RUN | B_MRD | B_MDE | B_ZLO;
  localparam logic [20:0] E_T1R   = B_RUN | B_MRD | B_MDE | B_ZLO | B_PCE;
  localparam logic [20:0] E_T2    = B_RUN | B_MDO | B_IRE;
  localparam logic [20:0] E_T3BR  = B_RUN | B_GRA | B_ROUT | B_CONE;
  localparam logic [20:0] E_T3JR  = B_RUN | B_GRA | B_ROUT | B_PCE;
  localparam logic [20:0] E_T3NOP = B_RUN;
  localparam logic [20:0] E_T4    = B_RUN | B_PCO | B_YE;
  localparam logic [20:0] E_T5    = B_RUN | B_COUT | B_ZLI | B_ZHI;
  localparam logic [20:0] E_T6T   = B_RUN | B_ZLO | B_PCE;
  localparam logic [20:0] E_T6N   = B_RUN | B_ZLO;
  localparam logic [20:0] E_HALT  = 21'h000000;

  branch_control_unit #(.RST_SETTLE(1)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Mem_ready(Mem_ready),
    .Start(Start), .DP_clear(DP_clear), .Run(Run), .PCout(PCout),
    .MAR_enable(MAR_enable), .IncPC(IncPC), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowout(ZLowout), .PC_enable(PC_enable), .MDR_read(MDR_read),
    .MDR_enable(MDR_enable), .MDRout(MDRout), .IR_enable(IR_enable), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .CON_enable(CON_enable),
    .Y_enable(Y_enable), .Cout(Cout)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic test_reset();
    Clear = 1'b0; IR = 32'h0; CON_FF = 1'b0; Mem_ready = 1'b0; Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (obs !== E_RST) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, E_RST);
      end
    end
    Clear = 1'b1;
    #1;
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL reset_settle: got %h expected %h", obs, E_RST);
    end
    @(negedge Clock);
    checks++;
    if (obs !== E_T0) begin
      errors++;
      $display("FAIL reset_to_t0: got %h expected %h", obs, E_T0);
    end
  endtask

  task automatic test_taken_branch();
    logic [20:0] exp_t [7];
    exp_t = '{E_T1R, E_T2, E_T3BR, E_T4, E_T5, E_T6T, E_T0};
    IR = 32'h91000023; CON_FF = 1'b1; Mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL taken_branch step %0d: got %h expected %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_not_taken_branch();
    logic [20:0] exp_t [7];
    exp_t = '{E_T1R, E_T2, E_T3BR, E_T4, E_T5, E_T6N, E_T0};
    IR = 32'h91080023; CON_FF = 1'b0; Mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL not_taken_branch step %0d: got %h expected %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [20:0] exp_t [10];
    logic        mr_t  [10];
    exp_t = '{E_T1W, E_T1W, E_T1W, E_T1R, E_T2, E_T3BR, E_T4, E_T5, E_T6T, E_T0};
    mr_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    IR = 32'h91000023; CON_FF = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      Mem_ready = mr_t[i];
      @(negedge Clock);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL mem_wait step %0d: got %h expected %h", i, obs, exp_t[i]);
      end
    end
    Mem_ready = 1'b1;
  endtask

  task automatic test_nop_other();
    logic [31:0] ir_t  [2];
    logic [20:0] exp_t [4];
    ir_t  = '{32'hC8000000, 32'h18000000};
    exp_t = '{E_T1R, E_T2, E_T3NOP, E_T0};
    for (int k = 0; k < 2; k++) begin
      IR = ir_t[k];
      for (int i = 0; i < 4; i++) begin
        @(posedge Clock); #1;
        @(negedge Clock);
        checks++;
        if (obs !== exp_t[i]) begin
          errors++;
          $display("FAIL nop_other ir=%h step %0d: got %h expected %h",
                   ir_t[k], i, obs, exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_jr_halt();
    logic [20:0] exp_t [4];
    exp_t = '{E_T1R, E_T2, E_T3JR, E_T0};
    IR = 32'h98000000;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL jr step %0d: got %h expected %h", i, obs, exp_t[i]);
      end
    end
    exp_t = '{E_T1R, E_T2, E_T3NOP, E_HALT};
    IR = 32'hD0000000;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      // Start raised while still in S_T3 must be ignored on the entry edge.
      Start = (i == 2) ? 1'b1 : 1'b0;
      @(negedge Clock);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL halt_entry step %0d: got %h expected %h", i, obs, exp_t[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      Start = (i == 19) ? 1'b1 : 1'b0;
      @(negedge Clock);
      checks++;
      if (obs !== E_HALT) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, E_HALT);
      end
    end
    @(posedge Clock); #1;
    Start = 1'b0;
    @(negedge Clock);
    checks++;
    if (obs !== E_T0) begin
      errors++;
      $display("FAIL halt_resume: got %h expected %h", obs, E_T0);
    end
  endtask

  task automatic test_reset_mid_branch();
    logic [20:0] exp_t [5];
    exp_t = '{E_T1R, E_T2, E_T3BR, E_T4, E_T5};
    IR = 32'h91000023; CON_FF = 1'b1; Mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++;
        $display("FAIL mid_reset_pre step %0d: got %h expected %h", i, obs, exp_t[i]);
      end
    end
    Clear = 1'b0;
    #1;
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected %h", obs, E_RST);
    end
    @(negedge Clock);
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL mid_reset_hold: got %h expected %h", obs, E_RST);
    end
    Clear = 1'b1;
    #1;
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL mid_reset_settle: got %h expected %h", obs, E_RST);
    end
    @(negedge Clock);
    checks++;
    if (obs !== E_T0) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h expected %h", obs, E_T0);
    end
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_not_taken_branch();
    test_mem_wait();
    test_nop_other();
    test_jr_halt();
    test_reset_mid_branch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
